qdrc_arb: RTL
=============

Name: qdrc_arb

Overview:
- Two-requester arbiter in front of the QDR controller user interface (rd/wr strobes, shared address, 2x-width data, byte enables).
- Port A is the high-priority fabric datapath; port B is the low-priority CPU/bus path, with a starvation guard.
- Issues at most one command per cycle and tracks outstanding reads in a tag FIFO, so returned read data reaches the port that requested it.

Parameters:
- DATA_WIDTH, 36, QDR word width; user data is 2*DATA_WIDTH.
- BW_WIDTH, 4, byte-write lanes per word; user enables are 2*BW_WIDTH.
- ADDR_WIDTH, 21, QDR burst address width.
- TAG_AW, 4, log2 of tag FIFO depth (16 outstanding reads).
- STARVE_LIMIT, 8, consecutive denied cycles after which B is forced.

Ports:
- clk in 1: controller clock (clk0 domain).
- reset_n in 1: synchronous, active-low reset.
- phy_rdy in 1: controller calibrated; no command is accepted while low.
- a_rd_strb, a_wr_strb in 1 each: port A request strobes, held until acked.
- a_addr in ADDR_WIDTH; a_wr_data in 2*DATA_WIDTH; a_wr_be in 2*BW_WIDTH.
- a_ack out 1: request accepted this cycle (combinational).
- a_rd_data out 2*DATA_WIDTH; a_rd_dvld out 1: read return for port A.
- b_rd_strb, b_wr_strb, b_addr, b_wr_data, b_wr_be, b_ack, b_rd_data, b_rd_dvld: same widths and meaning for port B.
- qdr_rd_strb, qdr_wr_strb out 1 each; qdr_addr out ADDR_WIDTH; qdr_wr_data out 2*DATA_WIDTH; qdr_wr_be out 2*BW_WIDTH: to controller.
- qdr_rd_data in 2*DATA_WIDTH; qdr_rd_dvld in 1: from controller.
- rd_outstanding out TAG_AW+1: tag FIFO occupancy.
- rd_underflow out 1: sticky error flag.

Behaviour:
- Reset (reset_n=0 at a clk edge) clears the following to 0: all outputs, the tag FIFO pointers and count, the starvation counter, and rd_underflow.
- Request rules:
  - A request is rd_strb|wr_strb. Strobes, address, data and enables are held stable until ack.
  - A request with both strobes set forwards both with the same address.
  - Dropping a request before ack is legal; nothing is issued for it.
- Eligibility: phy_rdy=1, and for a read-bearing request the tag FIFO is not full (count < 2^TAG_AW).
  - A write-only request is eligible regardless of FIFO state.
- Grant:
  - Default: A wins if eligible; otherwise B if eligible.
  - starve_cnt increments each cycle B is eligible but not granted, saturating at STARVE_LIMIT. It clears when B is granted or B has no request.
  - When starve_cnt==STARVE_LIMIT and B is eligible, B wins over A for that cycle.
- Ack: x_ack=1 in the cycle of grant, combinational from inputs and state. At most one of a_ack/b_ack is set per cycle.
- Issue:
  - The cycle after grant, qdr_* registers present the winner's strobes, address, data and enables.
  - With no grant, the strobes are 0. Address and data hold their last value.
  - Issue latency is 1 clk from ack.
- Tag FIFO:
  - On a granted read, push the port id (0=A, 1=B) at the grant edge.
  - On qdr_rd_dvld, pop the head.
  - Simultaneous push and pop leaves the count unchanged and both take effect.
  - Full: read-bearing requests are withheld (no ack).
- Read return:
  - Registered, 1 clk after qdr_rd_dvld. The head tag selects which port receives rd_data and a 1-cycle dvld; the other port's dvld stays 0.
  - Both x_rd_data outputs may carry the same data; only the dvld steers.
  - In-order return by the controller is required.
- Underflow: qdr_rd_dvld with an empty FIFO sets rd_underflow (sticky until reset), the pop is ignored, and no port dvld is asserted.
- phy_rdy deassert mid-operation:
  - No new acks; outstanding tags are retained and returns keep routing.
  - The qdr_* command already registered for this cycle still issues.
- Reset mid-operation: outstanding tags are discarded. Later qdr_rd_dvld pulses flag underflow.

Decomposition:
- Package qdrc_arb_pkg:
  - PORT_A=1'b0, PORT_B=1'b1 port-id constants.
  - Tag width constant.
  - Grant encoding: NONE, A, B.
- Sub-module qdrc_arb_tagfifo: 1-bit-wide synchronous FIFO, depth 2^TAG_AW. Push/pop, full/empty, count, and an underflow pulse.
- Arbitration, starvation counter and output registers live in the top module.

Test Plan:
- A-only stream: a_rd_strb held 5 cycles, addrs 0x10..0x14, controller returns 5 dvld pulses.
  - a_ack on 5 consecutive cycles; qdr_rd_strb 1 clk later.
  - 5 a_rd_dvld pulses, each 1 clk after qdr_rd_dvld; b_rd_dvld never set.
- Contention: A and B both write continuously with STARVE_LIMIT=8.
  - B is acked exactly once every 9 cycles.
  - starve_cnt returns to 0 after each B grant.
- Interleaved reads A, B, A, then returns with data 0xAA.., 0xBB.., 0xCC...
  - Data lands on a, b, a respectively, in order.
  - rd_outstanding goes 3 -> 0.
- FIFO full: 16 outstanding reads, no returns.
  - 17th read not acked; a write-only request from B is still acked.
  - One return frees a slot; the pending read is acked the next cycle.
- phy_rdy=0 with requests pending: no acks and no qdr strobes. Raise phy_rdy: the first ack comes the same cycle.
- Underflow and reset: qdr_rd_dvld with the FIFO empty -> rd_underflow=1, no port dvld.
  - reset_n low 1 cycle -> all outputs 0 and rd_underflow cleared.

Source files
------------

// File: rtl/qdrc_arb_pkg.sv
// Shared constants and types for the two-port QDR command arbiter.
// Port ids are what the tag FIFO stores to route read returns.
package qdrc_arb_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam int   TAG_W  = 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/qdrc_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the QDR controller.
// slave = arbiter view, master = requester/controller environment view.
interface qdrc_arb_if #(
    parameter int DATA_WIDTH = 36,
    parameter int BW_WIDTH   = 4,
    parameter int ADDR_WIDTH = 21
);
    // Handshake: a requester raises rd_strb and/or wr_strb and holds strobes,
    // address, data and enables stable until it sees ack high in the same
    // cycle; the request is consumed on that clock edge. Dropping a request
    // before ack is allowed and issues nothing. rd_dvld is a 1-cycle pulse.
    logic                      phy_rdy;

    logic                      a_rd_strb;
    logic                      a_wr_strb;
    logic [ADDR_WIDTH-1:0]     a_addr;
    logic [2*DATA_WIDTH-1:0]   a_wr_data;
    logic [2*BW_WIDTH-1:0]     a_wr_be;
    logic                      a_ack;
    logic [2*DATA_WIDTH-1:0]   a_rd_data;
    logic                      a_rd_dvld;

    logic                      b_rd_strb;
    logic                      b_wr_strb;
    logic [ADDR_WIDTH-1:0]     b_addr;
    logic [2*DATA_WIDTH-1:0]   b_wr_data;
    logic [2*BW_WIDTH-1:0]     b_wr_be;
    logic                      b_ack;
    logic [2*DATA_WIDTH-1:0]   b_rd_data;
    logic                      b_rd_dvld;

    logic                      qdr_rd_strb;
    logic                      qdr_wr_strb;
    logic [ADDR_WIDTH-1:0]     qdr_addr;
    logic [2*DATA_WIDTH-1:0]   qdr_wr_data;
    logic [2*BW_WIDTH-1:0]     qdr_wr_be;
    logic [2*DATA_WIDTH-1:0]   qdr_rd_data;
    logic                      qdr_rd_dvld;

    modport slave (
        input  phy_rdy,
        input  a_rd_strb, a_wr_strb, a_addr, a_wr_data, a_wr_be,
        output a_ack, a_rd_data, a_rd_dvld,
        input  b_rd_strb, b_wr_strb, b_addr, b_wr_data, b_wr_be,
        output b_ack, b_rd_data, b_rd_dvld,
        output qdr_rd_strb, qdr_wr_strb, qdr_addr, qdr_wr_data, qdr_wr_be,
        input  qdr_rd_data, qdr_rd_dvld
    );

    modport master (
        output phy_rdy,
        output a_rd_strb, a_wr_strb, a_addr, a_wr_data, a_wr_be,
        input  a_ack, a_rd_data, a_rd_dvld,
        output b_rd_strb, b_wr_strb, b_addr, b_wr_data, b_wr_be,
        input  b_ack, b_rd_data, b_rd_dvld,
        input  qdr_rd_strb, qdr_wr_strb, qdr_addr, qdr_wr_data, qdr_wr_be,
        output qdr_rd_data, qdr_rd_dvld
    );

endinterface

// File: rtl/qdrc_arb_tagfifo.sv
// Outstanding-read tag FIFO: one port id per read in flight, popped on return.
// A pop while empty is dropped and reported as a 1-cycle underflow pulse.
module qdrc_arb_tagfifo
    import qdrc_arb_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [TAG_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] head,
    output logic [AW:0]      count,
    output logic             underflow
);
    localparam int             DEPTH    = 1 << AW;
    localparam logic [AW:0]    FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        do_push   = push && !full;
        do_pop    = pop && !empty;
        underflow = pop && empty;
        wr_ptr_d  = wr_ptr_q + AW'(do_push);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        count_d   = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/qdrc_arb.sv
// Two-port arbiter in front of the QDR controller user interface: A has
// priority, B is forced after STARVE_LIMIT denied cycles; reads are tagged.
module qdrc_arb
    import qdrc_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 36,
    parameter int BW_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 21,
    parameter int TAG_AW       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    qdrc_arb_if.slave     bus,
    output logic [TAG_AW:0] rd_outstanding,
    output logic          rd_underflow
);
    localparam int DW  = 2 * DATA_WIDTH;
    localparam int BEW = 2 * BW_WIDTH;
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    grant_e           grant;
    logic             a_req, b_req, a_elig, b_elig;
    logic             fifo_full, fifo_empty, fifo_push, uf_pulse, pop_ok;
    logic [TAG_W-1:0] fifo_head, push_id;

    logic [SCW-1:0]        starve_q, starve_d;
    logic                  qdr_rd_strb_q, qdr_rd_strb_d;
    logic                  qdr_wr_strb_q, qdr_wr_strb_d;
    logic [ADDR_WIDTH-1:0] qdr_addr_q, qdr_addr_d;
    logic [DW-1:0]         qdr_wr_data_q, qdr_wr_data_d;
    logic [BEW-1:0]        qdr_wr_be_q, qdr_wr_be_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic                  a_dvld_q, a_dvld_d;
    logic                  b_dvld_q, b_dvld_d;
    logic                  underflow_q, underflow_d;

    always_comb begin
        a_req  = bus.a_rd_strb | bus.a_wr_strb;
        b_req  = bus.b_rd_strb | bus.b_wr_strb;
        a_elig = bus.phy_rdy && a_req && !(bus.a_rd_strb && fifo_full);
        b_elig = bus.phy_rdy && b_req && !(bus.b_rd_strb && fifo_full);

        grant = GNT_NONE;
        if (b_elig && (!a_elig || starve_q == SCW'(STARVE_LIMIT))) grant = GNT_B;
        else if (a_elig)                                          grant = GNT_A;

        fifo_push = ((grant == GNT_A) && bus.a_rd_strb) ||
                    ((grant == GNT_B) && bus.b_rd_strb);
        push_id   = (grant == GNT_B) ? PORT_B : PORT_A;

        // Counts only cycles where B could have gone but A took the slot.
        starve_d = starve_q;
        if (!b_req || grant == GNT_B)                      starve_d = '0;
        else if (b_elig && starve_q != SCW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
    end

    always_comb begin
        qdr_rd_strb_d = 1'b0;
        qdr_wr_strb_d = 1'b0;
        qdr_addr_d    = qdr_addr_q;
        qdr_wr_data_d = qdr_wr_data_q;
        qdr_wr_be_d   = qdr_wr_be_q;
        case (grant)
            GNT_A: begin
                qdr_rd_strb_d = bus.a_rd_strb;
                qdr_wr_strb_d = bus.a_wr_strb;
                qdr_addr_d    = bus.a_addr;
                qdr_wr_data_d = bus.a_wr_data;
                qdr_wr_be_d   = bus.a_wr_be;
            end
            GNT_B: begin
                qdr_rd_strb_d = bus.b_rd_strb;
                qdr_wr_strb_d = bus.b_wr_strb;
                qdr_addr_d    = bus.b_addr;
                qdr_wr_data_d = bus.b_wr_data;
                qdr_wr_be_d   = bus.b_wr_be;
            end
            default: ;
        endcase

        pop_ok      = bus.qdr_rd_dvld && !fifo_empty;
        rd_data_d   = bus.qdr_rd_dvld ? bus.qdr_rd_data : rd_data_q;
        a_dvld_d    = pop_ok && (fifo_head == PORT_A);
        b_dvld_d    = pop_ok && (fifo_head == PORT_B);
        underflow_d = underflow_q | uf_pulse;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_q      <= '0;
            qdr_rd_strb_q <= 1'b0;
            qdr_wr_strb_q <= 1'b0;
            qdr_addr_q    <= '0;
            qdr_wr_data_q <= '0;
            qdr_wr_be_q   <= '0;
            rd_data_q     <= '0;
            a_dvld_q      <= 1'b0;
            b_dvld_q      <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            starve_q      <= starve_d;
            qdr_rd_strb_q <= qdr_rd_strb_d;
            qdr_wr_strb_q <= qdr_wr_strb_d;
            qdr_addr_q    <= qdr_addr_d;
            qdr_wr_data_q <= qdr_wr_data_d;
            qdr_wr_be_q   <= qdr_wr_be_d;
            rd_data_q     <= rd_data_d;
            a_dvld_q      <= a_dvld_d;
            b_dvld_q      <= b_dvld_d;
            underflow_q   <= underflow_d;
        end
    end

    qdrc_arb_tagfifo #(.AW(TAG_AW)) u_tagfifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_id),
        .pop       (bus.qdr_rd_dvld),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (rd_outstanding),
        .underflow (uf_pulse)
    );

    assign bus.a_ack       = (grant == GNT_A);
    assign bus.b_ack       = (grant == GNT_B);
    assign bus.qdr_rd_strb = qdr_rd_strb_q;
    assign bus.qdr_wr_strb = qdr_wr_strb_q;
    assign bus.qdr_addr    = qdr_addr_q;
    assign bus.qdr_wr_data = qdr_wr_data_q;
    assign bus.qdr_wr_be   = qdr_wr_be_q;
    assign bus.a_rd_data   = rd_data_q;
    assign bus.b_rd_data   = rd_data_q;
    assign bus.a_rd_dvld   = a_dvld_q;
    assign bus.b_rd_dvld   = b_dvld_q;
    assign rd_underflow    = underflow_q;

endmodule
